// File: rtl/bpu_update_ctrl.sv
// Update sequencer for the fetch-stage BHT/BTB: accepts branch resolutions, issues mispredict
// redirects, and drives the single table write port with RMW updates and init/flush sweeps.
module bpu_update_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BHT_BTB_SIZE = 32,
  parameter int unsigned QDEPTH       = 4,
  localparam int unsigned ADDR_WIDTH  = $clog2(BHT_BTB_SIZE)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_pc,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  input  logic                  res_pred_taken,
  input  logic [DATA_WIDTH-1:0] res_pred_pc,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  flush_req,
  output logic                  flush_busy,
  input  logic                  wr_block,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [1:0]            rd_state,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_valid,
  output logic [1:0]            wr_state,
  output logic                  wr_tgt_en,
  output logic [DATA_WIDTH-1:0] wr_target
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [DATA_WIDTH-1:0] InitTarget = DATA_WIDTH'(32'h8000_0000);

  typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]           count_q, count_d;

  logic [ADDR_WIDTH-1:0] q_idx   [QDEPTH];
  logic                  q_taken [QDEPTH];
  logic [DATA_WIDTH-1:0] q_tgt   [QDEPTH];

  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  wr_en_q, wr_en_d, wr_valid_q, wr_valid_d, wr_tgt_en_q, wr_tgt_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]            wr_state_q, wr_state_d;
  logic [DATA_WIDTH-1:0] wr_target_q, wr_target_d;

  logic                  run, full, empty, accept, pop, mispredict;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [1:0]            cur_state, upd_state;

  assign run        = (state_q == StRun);
  assign full       = (count_q == (PW+1)'(QDEPTH));
  assign empty      = (count_q == '0);
  assign res_ready  = run && !full;
  assign flush_busy = !run;
  // A flush request in RUN swallows the same-cycle accept and pop.
  assign accept     = res_valid && res_ready && !flush_req;
  assign pop        = run && !empty && !wr_block && !flush_req;
  assign mispredict = (res_taken != res_pred_taken) || (res_taken && (res_target != res_pred_pc));
  assign head_idx   = q_idx[rptr_q];
  assign rd_addr    = head_idx;

  // Forward the in-flight write so back-to-back updates of one entry accumulate.
  always_comb begin
    cur_state = 2'b01;
    if (wr_en_q && (wr_addr_q == head_idx)) begin
      cur_state = wr_state_q;
    end else if (rd_valid) begin
      cur_state = rd_state;
    end
    if (q_taken[rptr_q]) begin
      upd_state = (cur_state == 2'b11) ? 2'b11 : cur_state + 2'b01;
    end else begin
      upd_state = (cur_state == 2'b00) ? 2'b00 : cur_state - 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_valid_d  = 1'b0;
    wr_state_d  = 2'b00;
    wr_tgt_en_d = 1'b0;
    wr_target_d = '0;
    unique case (state_q)
      StInit, StFlush: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = sweep_q;
        wr_state_d  = 2'b01;
        wr_tgt_en_d = 1'b1;
        wr_target_d = InitTarget;
        sweep_d     = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == ADDR_WIDTH'(BHT_BTB_SIZE - 1)) state_d = StRun;
      end
      StRun: begin
        if (flush_req) begin
          state_d = StFlush;
          sweep_d = '0;
        end else if (pop) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = head_idx;
          wr_valid_d  = 1'b1;
          wr_state_d  = upd_state;
          wr_tgt_en_d = q_taken[rptr_q];
          wr_target_d = q_tgt[rptr_q];
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (run && flush_req) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (accept) wptr_d = wptr_q + PW'(1);
      if (pop)    rptr_d = rptr_q + PW'(1);
      case ({accept, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    redirect_valid_d = accept && mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (accept && mispredict) begin
      redirect_pc_d = res_taken ? res_target : res_pc + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q          <= StInit;
      sweep_q          <= '0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_valid_q       <= 1'b0;
      wr_state_q       <= 2'b00;
      wr_tgt_en_q      <= 1'b0;
      wr_target_q      <= '0;
    end else begin
      state_q          <= state_d;
      sweep_q          <= sweep_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_valid_q       <= wr_valid_d;
      wr_state_q       <= wr_state_d;
      wr_tgt_en_q      <= wr_tgt_en_d;
      wr_target_q      <= wr_target_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_idx[wptr_q]   <= res_pc[ADDR_WIDTH+1:2];
      q_taken[wptr_q] <= res_taken;
      q_tgt[wptr_q]   <= res_target;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_valid       = wr_valid_q;
  assign wr_state       = wr_state_q;
  assign wr_tgt_en      = wr_tgt_en_q;
  assign wr_target      = wr_target_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl; table writes and redirects are checked against
// expectation queues filled when each resolution is accepted.
module tb_bpu_update_ctrl;

  logic        clk, arst_n;
  logic        res_valid, res_ready, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_req, flush_busy, wr_block;
  logic [4:0]  rd_addr, wr_addr;
  logic        rd_valid, wr_en, wr_valid, wr_tgt_en;
  logic [1:0]  rd_state, wr_state;
  logic [31:0] wr_target;

  typedef struct packed {
    logic [4:0]  addr;
    logic        valid;
    logic [1:0]  state;
    logic        tgt_en;
    logic [31:0] target;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  wr_t         m_obs, m_exp;
  logic [31:0] m_rd;
  int          vectors, miscompares;

  bpu_update_ctrl #(.DATA_WIDTH(32), .BHT_BTB_SIZE(32), .QDEPTH(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_req(flush_req), .flush_busy(flush_busy), .wr_block(wr_block),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_state(rd_state),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_state(wr_state),
    .wr_tgt_en(wr_tgt_en), .wr_target(wr_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard side: every observed write/redirect must match the oldest expectation.
  always @(negedge clk) begin
    if (arst_n) begin
      if (wr_en) begin
        m_obs = {wr_addr, wr_valid, wr_state, wr_tgt_en, wr_target};
        vectors++;
        assert (exp_wr_q.size() != 0) else begin
          miscompares++;
          $error("FAIL wr_unexpected observed=%h expected=none", m_obs);
        end
        if (exp_wr_q.size() != 0) begin
          m_exp = exp_wr_q.pop_front();
          vectors++;
          assert (m_obs === m_exp) else begin
            miscompares++;
            $error("FAIL wr observed=%h expected=%h", m_obs, m_exp);
          end
        end
      end
      if (redirect_valid) begin
        vectors++;
        assert (exp_rd_q.size() != 0) else begin
          miscompares++;
          $error("FAIL redirect_unexpected observed=%h expected=none", redirect_pc);
        end
        if (exp_rd_q.size() != 0) begin
          m_rd = exp_rd_q.pop_front();
          vectors++;
          assert (redirect_pc === m_rd) else begin
            miscompares++;
            $error("FAIL redirect_pc observed=%h expected=%h", redirect_pc, m_rd);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 32; i++) begin
      exp_wr_q.push_back({5'(i), 1'b0, 2'b01, 1'b1, 32'h8000_0000});
    end
  endtask

  // Offer one resolution, wait (bounded) for acceptance, and queue its expectations.
  task automatic send(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic ptaken, input logic [31:0] ppc, input logic [1:0] exp_state,
                      input bit track);
    bit ok;
    ok = 1'b0;
    res_valid = 1'b1; res_pc = pc; res_taken = taken; res_target = tgt;
    res_pred_taken = ptaken; res_pred_pc = ppc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_ready) begin ok = 1'b1; break; end
    end
    check("accept", 64'(ok), 64'd1);
    if (ok && track) begin
      exp_wr_q.push_back({pc[6:2], 1'b1, exp_state, taken, tgt});
      if ((taken != ptaken) || (taken && (tgt != ppc))) begin
        exp_rd_q.push_back(taken ? tgt : pc + 32'd4);
      end
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0;
    arst_n = 1'b0; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_pc = '0; flush_req = 1'b0; wr_block = 1'b0;
    rd_valid = 1'b0; rd_state = 2'b00;

    repeat (2) @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_redirect", 64'(redirect_valid), 64'd0);
    check("rst_busy", 64'(flush_busy), 64'd1);
    check("rst_ready", 64'(res_ready), 64'd0);

    push_sweep();
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_busy", 64'(flush_busy), 64'd1);
      check("init_ready", 64'(res_ready), 64'd0);
    end
    @(negedge clk);
    check("run_busy", 64'(flush_busy), 64'd0);
    check("run_ready", 64'(res_ready), 64'd1);
    @(posedge clk); #1;
    wait_idle();

    // Taken mispredict on an invalid entry: WNT -> WT, redirect to target.
    rd_valid = 1'b0;
    send(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0000, 2'b10, 1'b1);
    wait_idle();

    // Back-to-back taken updates of one entry rely on write forwarding.
    rd_valid = 1'b1; rd_state = 2'b01;
    send(32'h8000_0020, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0200, 2'b10, 1'b1);
    send(32'h8000_0020, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0200, 2'b11, 1'b1);
    send(32'h8000_0020, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0200, 2'b11, 1'b1);
    wait_idle();

    // Correctly predicted not-taken: no redirect, WNT -> SNT, no target write.
    send(32'h8000_0008, 1'b0, 32'h0000_1234, 1'b0, 32'h8000_000C, 2'b00, 1'b1);
    wait_idle();

    // Blocked write port fills the queue; the fifth resolution waits for a pop.
    wr_block = 1'b1; rd_state = 2'b10;
    for (int i = 0; i < 4; i++) begin
      send(32'h8000_0040 + 32'(4 * i), 1'b1, 32'h8000_0400 + 32'(16 * i), 1'b1,
           32'h8000_0400 + 32'(16 * i), 2'b11, 1'b1);
    end
    res_valid = 1'b1; res_pc = 32'h8000_0050;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", 64'(res_ready), 64'd0);
    end
    @(posedge clk); #1;
    wr_block = 1'b0;
    send(32'h8000_0050, 1'b1, 32'h8000_0440, 1'b1, 32'h8000_0440, 2'b11, 1'b1);
    wait_idle();

    // Flush discards queued updates and runs a full invalidate sweep.
    wr_block = 1'b1;
    send(32'h8000_0060, 1'b1, 32'h8000_0600, 1'b1, 32'h8000_0600, 2'b11, 1'b0);
    send(32'h8000_0064, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
    push_sweep();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("flush_busy", 64'(flush_busy), 64'd1);
      check("flush_ready", 64'(res_ready), 64'd0);
    end
    @(negedge clk);
    check("flush_done_busy", 64'(flush_busy), 64'd0);
    check("flush_done_ready", 64'(res_ready), 64'd1);
    @(posedge clk); #1;
    wr_block = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bpu_update_ctrl.md
Name: bpu_update_ctrl

Overview:
- Sequences the single write port of the BHT/BTB arrays that sit beside the fetch-stage branch predictor.
- Accepts branch resolutions from EXECUTE, detects mispredicts and issues a registered redirect.
- Queues table updates and applies them one per cycle as a read-modify-write with a 2-bit saturating counter.
- Owns the table initialise sweep after reset and the invalidate sweep on flush (fence.i / context change).

Parameters:
- DATA_WIDTH, 32, PC/target width
- BHT_BTB_SIZE, 32, table entries (power of 2); ADDR_WIDTH = $clog2(BHT_BTB_SIZE)
- QDEPTH, 4, update-queue entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- res_valid  in  1  EXECUTE has a resolved conditional branch
- res_ready  out  1  resolution accepted when res_valid && res_ready
- res_pc  in  DATA_WIDTH  branch PC
- res_taken  in  1  actual outcome
- res_target  in  DATA_WIDTH  actual taken target
- res_pred_taken  in  1  prediction made at fetch
- res_pred_pc  in  DATA_WIDTH  predicted target made at fetch
- redirect_valid  out  1  one-cycle mispredict pulse
- redirect_pc  out  DATA_WIDTH  correct next PC
- flush_req  in  1  request invalidate of the whole table
- flush_busy  out  1  INIT or FLUSH sweep in progress
- wr_block  in  1  table write port unavailable this cycle, so no pop
- rd_addr  out  ADDR_WIDTH  table read index, combinational from the queue head
- rd_valid  in  1  valid bit at rd_addr, combinational
- rd_state  in  2  counter at rd_addr, combinational
- wr_en  out  1  table write strobe
- wr_addr  out  ADDR_WIDTH  write index
- wr_valid  out  1  valid bit to write
- wr_state  out  2  counter to write
- wr_tgt_en  out  1  also write the target field
- wr_target  out  DATA_WIDTH  target to write

Behaviour:
- Reset values:
  - All registered outputs are 0.
  - FSM is in INIT, sweep counter is 0, queue is empty.
- Counter encoding:
  - 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Taken: saturating +1. Not-taken: saturating -1.
  - If rd_valid=0, the current state is treated as WNT regardless of rd_state.
- Accept and redirect:
  - res_ready = (state==RUN) && !full.
  - On accept: mispredict = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_pc).
  - On mispredict, redirect_valid is asserted the next cycle for exactly one cycle.
  - redirect_pc = res_taken ? res_target : res_pc+4.
  - redirect_valid is independent of queue draining.
  - {res_pc[ADDR_WIDTH+1:2], res_taken, res_target} is pushed into the queue.
- FSM:
  - INIT: each cycle write addr=cnt, valid=0, state=01, tgt_en=1, target=32'h8000_0000; cnt++.
    - Go to RUN after the write of addr SIZE-1, so the sweep takes exactly BHT_BTB_SIZE cycles.
  - RUN: if the queue is non-empty and !wr_block, pop the head.
    - Next cycle (registered): wr_en=1, wr_addr=head index, wr_valid=1, wr_state=updated counter, wr_tgt_en=taken, wr_target=target.
    - Throughput is one update per cycle.
    - flush_req in RUN: the queue is cleared, any accept that cycle is dropped, cnt=0, go to FLUSH.
  - FLUSH: same writes as INIT, then go to RUN. flush_req is ignored while in FLUSH.
- flush_busy = state is INIT or FLUSH. Queue push and pop are inhibited while busy.
- Forwarding:
  - If the popped index equals the wr_addr of the write currently driven (wr_en=1), use that wr_state as the current value instead of rd_valid/rd_state.
  - This makes back-to-back updates to the same entry accumulate correctly.
- Queue: pointers wrap modulo QDEPTH. There is no full-bypass path. Push and pop in the same cycle are allowed when not full.
- Reset mid-operation: every state is abandoned immediately and INIT restarts after arst_n deasserts.

Test Plan:
- Release reset -> 32 wr_en cycles, addr 0..31, valid=0, state=01, target=0x8000_0000; flush_busy and res_ready=0 throughout; res_ready=1 the cycle after.
- Accept pc=0x8000_0010, taken=1, target=0x8000_0100, pred_taken=0, rd_valid=0 -> redirect_valid pulse with redirect_pc=0x8000_0100; write addr 4, state=10, tgt_en=1, target=0x8000_0100.
- Three back-to-back taken resolutions at pc=0x8000_0020, rd_state held at 01 with rd_valid=1 -> writes addr 8 with states 10, 11, 11 via forwarding.
- Accept pc=0x8000_0008, taken=0, pred_taken=0, rd_valid=1, rd_state=01 -> no redirect; write addr 2, state=00, tgt_en=0.
- wr_block=1 with 5 resolutions offered -> 4 accepted, res_ready=0 after the 4th and the 5th held; release wr_block -> 4 writes in order, then the 5th is accepted.
- 2 entries queued, flush_req pulse -> queued updates never written; 32-cycle invalidate sweep with flush_busy=1; RUN resumes.
